// File: rtl/superscalar_pkg.sv
// Shared core types: ROB/data widths and reservation-station entry layout,
// plus the operand wakeup helper used by both dispatch bypass and CDB snoop.
package superscalar_pkg;

  localparam int ROB_IX_W = 3;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic                rdy;
    logic [DATA_W-1:0]   val;
    logic [ROB_IX_W-1:0] tag;
  } rs_operand_t;

  typedef struct packed {
    logic                busy;
    logic [ROB_IX_W-1:0] rob_ix;
    rs_operand_t         op1;
    rs_operand_t         op2;
  } rs_entry_t;

  // A waiting operand whose producer is on the CDB takes the broadcast value.
  function automatic rs_operand_t capture_operand(
    input rs_operand_t         op,
    input logic                cdb_valid,
    input logic [ROB_IX_W-1:0] cdb_tag,
    input logic [DATA_W-1:0]   cdb_data
  );
    rs_operand_t res;
    res = op;
    if (!op.rdy && cdb_valid && (op.tag == cdb_tag)) begin
      res.rdy = 1'b1;
      res.val = cdb_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_priority_pick.sv
// Lowest-index one-hot picker: grants the least significant set request bit.
module rs_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         found
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + N'(1));
  assign found = |req;

endmodule

// File: rtl/mul_reservation_station.sv
// Multiplier reservation station: holds pending multiplies, wakes operands
// from the CDB and issues the lowest-index ready entry as a one-cycle pulse.
module mul_reservation_station #(
  parameter int DEPTH    = 4,
  parameter int ROB_IX_W = 3,
  parameter int DATA_W   = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush_in,
  input  logic                       dispatch_valid_in,
  output logic                       dispatch_ready_out,
  input  logic [ROB_IX_W-1:0]        dispatch_rob_ix_in,
  input  logic                       dispatch_rdy1_in,
  input  logic                       dispatch_rdy2_in,
  input  logic [DATA_W-1:0]          dispatch_val1_in,
  input  logic [DATA_W-1:0]          dispatch_val2_in,
  input  logic [ROB_IX_W-1:0]        dispatch_tag1_in,
  input  logic [ROB_IX_W-1:0]        dispatch_tag2_in,
  input  logic                       cdb_valid_in,
  input  logic [ROB_IX_W-1:0]        cdb_rob_ix_in,
  input  logic [DATA_W-1:0]          cdb_data_in,
  input  logic                       fu_ready_in,
  output logic                       issue_valid_out,
  output logic [DATA_W-1:0]          issue_rval1_out,
  output logic [DATA_W-1:0]          issue_rval2_out,
  output logic [ROB_IX_W-1:0]        issue_rob_ix_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_out
);

  import superscalar_pkg::*;

  localparam int OCC_W = $clog2(DEPTH+1);

  rs_entry_t           entries_q [DEPTH];
  rs_entry_t           entries_d [DEPTH];
  logic [DEPTH-1:0]    busy, ready, free_grant, ready_grant;
  logic                free_found, ready_found;
  logic                do_dispatch, do_issue;
  rs_entry_t           new_entry;
  logic [DATA_W-1:0]   sel_val1, sel_val2;
  logic [ROB_IX_W-1:0] sel_rob_ix;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy[i]  = entries_q[i].busy;
      ready[i] = entries_q[i].busy & entries_q[i].op1.rdy & entries_q[i].op2.rdy;
    end
  end

  rs_priority_pick #(.N(DEPTH)) u_free_pick (
    .req   (~busy),
    .grant (free_grant),
    .found (free_found)
  );

  rs_priority_pick #(.N(DEPTH)) u_ready_pick (
    .req   (ready),
    .grant (ready_grant),
    .found (ready_found)
  );

  // Slot availability comes from registered state only, so an issue this
  // cycle never frees a slot for a dispatch in the same cycle.
  assign dispatch_ready_out = ~&busy;
  assign do_dispatch        = dispatch_valid_in && dispatch_ready_out && free_found;
  assign do_issue           = fu_ready_in && !issue_valid_out && ready_found;

  always_comb begin
    occupancy_out = '0;
    for (int i = 0; i < DEPTH; i++) occupancy_out = occupancy_out + OCC_W'(busy[i]);
  end

  always_comb begin
    sel_val1   = '0;
    sel_val2   = '0;
    sel_rob_ix = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_grant[i]) begin
        sel_val1   = entries_q[i].op1.val;
        sel_val2   = entries_q[i].op2.val;
        sel_rob_ix = entries_q[i].rob_ix;
      end
    end
  end

  always_comb begin
    new_entry.busy   = 1'b1;
    new_entry.rob_ix = dispatch_rob_ix_in;
    new_entry.op1    = capture_operand('{dispatch_rdy1_in, dispatch_val1_in, dispatch_tag1_in},
                                       cdb_valid_in, cdb_rob_ix_in, cdb_data_in);
    new_entry.op2    = capture_operand('{dispatch_rdy2_in, dispatch_val2_in, dispatch_tag2_in},
                                       cdb_valid_in, cdb_rob_ix_in, cdb_data_in);
  end

  // NOTE: combinational next-state uses blocking '=' and starts from a full
  // default (hold), so every path assigns every field and no latch is inferred.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].busy) begin
        entries_d[i].op1 = capture_operand(entries_q[i].op1, cdb_valid_in, cdb_rob_ix_in, cdb_data_in);
        entries_d[i].op2 = capture_operand(entries_q[i].op2, cdb_valid_in, cdb_rob_ix_in, cdb_data_in);
      end
      if (do_issue && ready_grant[i]) entries_d[i].busy = 1'b0;
      if (do_dispatch && free_grant[i]) entries_d[i] = new_entry;
      if (flush_in) entries_d[i].busy = 1'b0;
    end
  end

  // NOTE: only busy needs a reset for correctness; payload fields are cleared
  // too so the entry array has one uniform async-reset flop style.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      issue_valid_out  <= 1'b0;
      issue_rval1_out  <= '0;
      issue_rval2_out  <= '0;
      issue_rob_ix_out <= '0;
    end else begin
      entries_q       <= entries_d;
      issue_valid_out <= do_issue && !flush_in;
      if (do_issue) begin
        issue_rval1_out  <= sel_val1;
        issue_rval2_out  <= sel_val2;
        issue_rob_ix_out <= sel_rob_ix;
      end
    end
  end

endmodule
